iir_ch_sched: RTL and testbench
===============================

# iir_ch_sched

Round-robin scheduler that time-shares one deemphasis IIR core between the left and right audio channels of the FM stereo path. It pops samples from the per-channel input FIFOs, issues them to the core with a channel tag, and writes each result into the matching per-channel output FIFO. It sits between the stereo demux FIFOs and the deemphasis output FIFOs, replacing two dedicated IIR instances.

## Interface
Parameters:
- DATA_WIDTH, 32, sample width for FIFOs and the core
- CNT_WIDTH, 16, width of the per-channel processed-sample counters

Ports:
- clock  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- left_in_dout  in  DATA_WIDTH  head of the left input FIFO (show-ahead)
- left_in_empty  in  1  left input FIFO empty
- left_in_rd_en  out  1  pop the left input FIFO
- right_in_dout / right_in_empty / right_in_rd_en  same as left, for the right channel
- core_start  out  1  one-cycle start pulse to the shared IIR core
- core_ch  out  1  channel select for the core's state and coefficient bank (0=left, 1=right)
- core_din  out  DATA_WIDTH  registered sample to the core
- core_done  in  1  core result valid, one-cycle pulse
- core_dout  in  DATA_WIDTH  core result
- left_out_din  out  DATA_WIDTH  data to the left output FIFO
- left_out_wr_en  out  1  write strobe for the left output FIFO
- left_out_full  in  1  left output FIFO full
- right_out_din / right_out_wr_en / right_out_full  same as left, for the right channel
- busy  out  1  high whenever the FSM is not in IDLE
- left_cnt, right_cnt  out  CNT_WIDTH  samples written per channel; wrap modulo 2^CNT_WIDTH

## Operation
- Channel eligibility: a channel is eligible when its in_empty=0 and its out_full=0. Output full is checked only at grant. The output FIFO has a single writer, so space cannot vanish before the write.
- Priority: a last_ch register holds the previously granted channel. The other channel is tried first; if it is not eligible, last_ch is tried.
- FSM states:
  - IDLE: if any channel is eligible, grant it. For one cycle, assert its in_rd_en, register its in_dout into core_din, and set core_ch. Go to ISSUE.
  - ISSUE: core_start=1 for one cycle. Go to WAIT.
  - WAIT: hold core_din and core_ch stable. On core_done=1, capture core_dout into a result register and go to WRITE.
  - WRITE: drive the granted channel's out_din with the result and assert its out_wr_en for one cycle. Increment that channel's counter, set last_ch to the granted channel, and go to IDLE.
- core_done is honoured only in WAIT. A core_done pulse in any other state is ignored and has no side effects.
- Only one of left_in_rd_en / right_in_rd_en is ever high, and only in the grant cycle. The same rule applies to left_out_wr_en / right_out_wr_en in WRITE.
- out_din for the non-granted channel holds its previous value. Its wr_en stays 0.
- No channel starvation: when both channels stay eligible, grants strictly alternate L,R,L,R.

## Timing
- Reset values:
  - FSM in IDLE; last_ch=1, so left has priority first after reset.
  - All rd_en, wr_en and core_start = 0; busy=0.
  - core_ch=0; core_din, both out_din, result register and counters = 0.
- Reset mid-operation: return to IDLE within the same edge and clear all strobes. A sample already popped but not yet written is dropped. The bench must expect this loss and no duplicate write.
- Latency: with core latency L (core_done asserted L≥1 cycles after the core_start cycle), the grant-to-wr_en delay is 2+L cycles. Throughput is one sample per 3+L cycles.
- IDLE always takes at least one cycle between samples; there is no back-to-back grant from WRITE.
- Strobe alignment: in_rd_en and core_din capture happen on the same edge (show-ahead FIFO); wr_en and out_din are valid in the same cycle.

## Test plan
- Left-only, 4 samples 0x00000001..0x00000004 with a core model that returns din+1 at L=2 → left_out gets 2,3,4,5; right_out_wr_en never asserts; left_cnt=4; 5 cycles per sample.
- Both FIFOs non-empty (L: 0x10,0x11; R: 0x20,0x21) → core_ch sequence 0,1,0,1; outputs L:0x11,0x12 and R:0x21,0x22.
- right_out_full=1 with both channels loaded → only left is served and right_in_rd_en stays 0. Release full → right resumes on the next IDLE.
- Spurious core_done pulse in IDLE and in ISSUE → no write and no state change; the real done in WAIT produces exactly one wr_en.
- Reset asserted during WAIT → the next cycle shows all strobes 0, busy=0 and counters 0. After release, the first grant goes to left, and the dropped sample is never written.
- Counter wrap with CNT_WIDTH=2 → after 5 left samples, left_cnt=1.

Source files
------------

// File: rtl/iir_ch_sched.sv
// Round-robin scheduler sharing one deemphasis IIR core between the left and
// right channels: pops an input FIFO, runs the core, writes the matching output FIFO.
module iir_ch_sched #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] left_in_dout,
    input  logic                  left_in_empty,
    output logic                  left_in_rd_en,
    input  logic [DATA_WIDTH-1:0] right_in_dout,
    input  logic                  right_in_empty,
    output logic                  right_in_rd_en,
    output logic                  core_start,
    output logic                  core_ch,
    output logic [DATA_WIDTH-1:0] core_din,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_dout,
    output logic [DATA_WIDTH-1:0] left_out_din,
    output logic                  left_out_wr_en,
    input  logic                  left_out_full,
    output logic [DATA_WIDTH-1:0] right_out_din,
    output logic                  right_out_wr_en,
    input  logic                  right_out_full,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  left_cnt,
    output logic [CNT_WIDTH-1:0]  right_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_ch;
    logic                  r_core_start;
    logic                  r_core_ch;
    logic [DATA_WIDTH-1:0] r_core_din;
    logic [DATA_WIDTH-1:0] r_left_out_din;
    logic [DATA_WIDTH-1:0] r_right_out_din;
    logic                  r_left_wr_en;
    logic                  r_right_wr_en;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_left_cnt;
    logic [CNT_WIDTH-1:0]  r_right_cnt;

    logic                  w_left_elig;
    logic                  w_right_elig;
    logic                  w_grant;
    logic                  w_grant_ch;

    // Output-full is only looked at here; this block is the sole writer.
    assign w_left_elig  = !left_in_empty  && !left_out_full;
    assign w_right_elig = !right_in_empty && !right_out_full;

    // Next state and grant; the pop strobe must land in the grant cycle itself.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_ch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset) begin
                    if (r_last_ch) begin
                        if (w_left_elig) begin
                            w_grant    = 1'b1;
                            w_grant_ch = 1'b0;
                        end else if (w_right_elig) begin
                            w_grant    = 1'b1;
                            w_grant_ch = 1'b1;
                        end
                    end else begin
                        if (w_right_elig) begin
                            w_grant    = 1'b1;
                            w_grant_ch = 1'b1;
                        end else if (w_left_elig) begin
                            w_grant    = 1'b1;
                            w_grant_ch = 1'b0;
                        end
                    end
                end
                if (w_grant) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign left_in_rd_en  = w_grant && !w_grant_ch;
    assign right_in_rd_en = w_grant &&  w_grant_ch;

    // State, datapath and strobe registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_last_ch       <= 1'b1;
            r_core_start    <= 1'b0;
            r_core_ch       <= 1'b0;
            r_core_din      <= '0;
            r_left_out_din  <= '0;
            r_right_out_din <= '0;
            r_left_wr_en    <= 1'b0;
            r_right_wr_en   <= 1'b0;
            r_busy          <= 1'b0;
            r_left_cnt      <= '0;
            r_right_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_core_start  <= w_grant;
            r_left_wr_en  <= 1'b0;
            r_right_wr_en <= 1'b0;
            if (w_grant) begin
                r_core_ch  <= w_grant_ch;
                r_core_din <= w_grant_ch ? right_in_dout : left_in_dout;
            end
            // The per-channel out_din register doubles as the result register.
            if (r_state == S_WAIT && core_done) begin
                if (r_core_ch) begin
                    r_right_out_din <= core_dout;
                    r_right_wr_en   <= 1'b1;
                end else begin
                    r_left_out_din  <= core_dout;
                    r_left_wr_en    <= 1'b1;
                end
            end
            if (r_state == S_WRITE) begin
                r_last_ch <= r_core_ch;
                if (r_core_ch) begin
                    r_right_cnt <= r_right_cnt + CNT_WIDTH'(1);
                end else begin
                    r_left_cnt  <= r_left_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign core_start      = r_core_start;
    assign core_ch         = r_core_ch;
    assign core_din        = r_core_din;
    assign left_out_din    = r_left_out_din;
    assign left_out_wr_en  = r_left_wr_en;
    assign right_out_din   = r_right_out_din;
    assign right_out_wr_en = r_right_wr_en;
    assign busy            = r_busy;
    assign left_cnt        = r_left_cnt;
    assign right_cnt       = r_right_cnt;

endmodule

// File: tb/tb_iir_ch_sched.sv
// Bench for iir_ch_sched: queue-based FIFOs, a din+1 core of programmable latency,
// and a cycle-level scheduling model checked every clock against two DUT instances.
module tb_iir_ch_sched;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] left_in_dout, right_in_dout;
    logic          left_in_empty, right_in_empty;
    logic          left_in_rd_en, right_in_rd_en;
    logic          core_start, core_ch, core_done;
    logic [DW-1:0] core_din, core_dout;
    logic [DW-1:0] left_out_din, right_out_din;
    logic          left_out_wr_en, right_out_wr_en;
    logic          left_out_full, right_out_full;
    logic          busy;
    logic [CW-1:0] left_cnt, right_cnt;

    logic          d2_left_in_rd_en, d2_right_in_rd_en;
    logic          d2_core_start, d2_core_ch;
    logic [DW-1:0] d2_core_din, d2_left_out_din, d2_right_out_din;
    logic          d2_left_out_wr_en, d2_right_out_wr_en, d2_busy;
    logic [1:0]    d2_left_cnt, d2_right_cnt;

    always #5 clock = ~clock;

    iir_ch_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clock(clock), .reset(reset),
        .left_in_dout(left_in_dout), .left_in_empty(left_in_empty), .left_in_rd_en(left_in_rd_en),
        .right_in_dout(right_in_dout), .right_in_empty(right_in_empty), .right_in_rd_en(right_in_rd_en),
        .core_start(core_start), .core_ch(core_ch), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout),
        .left_out_din(left_out_din), .left_out_wr_en(left_out_wr_en), .left_out_full(left_out_full),
        .right_out_din(right_out_din), .right_out_wr_en(right_out_wr_en), .right_out_full(right_out_full),
        .busy(busy), .left_cnt(left_cnt), .right_cnt(right_cnt)
    );

    // Narrow-counter instance sharing all stimulus, for counter wrap.
    iir_ch_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .left_in_dout(left_in_dout), .left_in_empty(left_in_empty), .left_in_rd_en(d2_left_in_rd_en),
        .right_in_dout(right_in_dout), .right_in_empty(right_in_empty), .right_in_rd_en(d2_right_in_rd_en),
        .core_start(d2_core_start), .core_ch(d2_core_ch), .core_din(d2_core_din),
        .core_done(core_done), .core_dout(core_dout),
        .left_out_din(d2_left_out_din), .left_out_wr_en(d2_left_out_wr_en), .left_out_full(left_out_full),
        .right_out_din(d2_right_out_din), .right_out_wr_en(d2_right_out_wr_en), .right_out_full(right_out_full),
        .busy(d2_busy), .left_cnt(d2_left_cnt), .right_cnt(d2_right_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Environment and reference model state
    logic [DW-1:0] lq[$], rq[$], exp_l[$], exp_r[$];
    int            grants_ch[$];
    int            wr_cyc_l[$];
    int            cyc = 0;
    int            lat = 2;
    int            n_wr_l = 0, n_wr_r = 0, n_spur = 0;
    bit            spur_idle = 1'b0, spur_grant = 1'b0;
    bit            m_pend = 1'b0, m_ch = 1'b0, m_prev = 1'b1, m_busy = 1'b0;
    int            m_g = 0, m_due = 0;
    logic [DW-1:0] m_din = '0, m_last_l = '0, m_last_r = '0;
    int unsigned   m_cnt_l = 0, m_cnt_r = 0;
    int            core_cnt = 0;
    logic [DW-1:0] core_val = '0;

    // Per-cycle check of the ending cycle, then advance model, FIFOs and core.
    always @(posedge clock) begin
        logic          el, er, gnt, gch, wl, wr, d;
        logic [1:0]    erd;
        logic [DW-1:0] want_l, want_r;
        el  = !left_in_empty  && !left_out_full;
        er  = !right_in_empty && !right_out_full;
        gnt = 1'b0;
        gch = 1'b0;
        if (!m_pend && !reset) begin
            if (el && er) begin gnt = 1'b1; gch = !m_prev; end
            else if (el)  begin gnt = 1'b1; gch = 1'b0;    end
            else if (er)  begin gnt = 1'b1; gch = 1'b1;    end
        end
        erd    = gnt ? (gch ? 2'b10 : 2'b01) : 2'b00;
        wl     = m_pend && (cyc == m_due) && !m_ch;
        wr     = m_pend && (cyc == m_due) &&  m_ch;
        want_l = m_last_l;
        want_r = m_last_r;
        if (wl) begin
            want_l = (exp_l.size() != 0) ? exp_l.pop_front() : '0;
            m_last_l = want_l;
            n_wr_l++;
            wr_cyc_l.push_back(cyc);
        end
        if (wr) begin
            want_r = (exp_r.size() != 0) ? exp_r.pop_front() : '0;
            m_last_r = want_r;
            n_wr_r++;
        end
        if (cyc != 0) begin
            chk("rd_en", {right_in_rd_en, left_in_rd_en}, erd);
            chk("d2_rd_en", {d2_right_in_rd_en, d2_left_in_rd_en}, erd);
            chk("busy", {d2_busy, busy}, {m_busy, m_busy});
            chk("core_start", {d2_core_start, core_start}, {2{m_pend && (cyc == m_g + 1)}});
            if (m_pend) begin
                chk("core_sel", {core_ch, core_din}, {m_ch, m_din});
                chk("d2_core_sel", {d2_core_ch, d2_core_din}, {m_ch, m_din});
            end
            chk("wr_en", {right_out_wr_en, left_out_wr_en}, {wr, wl});
            chk("d2_wr_en", {d2_right_out_wr_en, d2_left_out_wr_en}, {wr, wl});
            chk("left_out_din", {d2_left_out_din, left_out_din}, {want_l, want_l});
            chk("right_out_din", {d2_right_out_din, right_out_din}, {want_r, want_r});
            chk("cnt", {left_cnt, right_cnt}, {CW'(m_cnt_l), CW'(m_cnt_r)});
            chk("d2_cnt", {d2_left_cnt, d2_right_cnt}, {2'(m_cnt_l), 2'(m_cnt_r)});
        end
        if (wl || wr) begin
            m_pend = 1'b0;
            m_busy = 1'b0;
            m_prev = m_ch;
            if (wl) m_cnt_l++; else m_cnt_r++;
        end
        if (gnt) begin
            m_pend = 1'b1;
            m_busy = 1'b1;
            m_ch   = gch;
            m_g    = cyc;
            m_due  = cyc + 2 + lat;
            m_din  = gch ? rq[0] : lq[0];
            grants_ch.push_back(int'(gch));
        end
        if (left_in_rd_en  && lq.size() != 0) void'(lq.pop_front());
        if (right_in_rd_en && rq.size() != 0) void'(rq.pop_front());
        if (core_start) begin
            core_cnt = lat;
            core_val = core_din + DW'(1);
        end
        d = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            d = (core_cnt == 0);
        end
        if (reset) begin
            // An in-flight sample is lost on reset and must never be written.
            if (m_pend) begin
                if (m_ch) void'(exp_r.pop_front());
                else      void'(exp_l.pop_front());
            end
            m_pend = 1'b0; m_busy = 1'b0; m_prev = 1'b1;
            m_last_l = '0; m_last_r = '0; m_cnt_l = 0; m_cnt_r = 0;
            core_cnt = 0;
            d = 1'b0;
        end
        if (!d && ((spur_idle && !m_pend) || (spur_grant && gnt))) begin
            core_done <= 1'b1;
            core_dout <= DW'($urandom);
            spur_idle  = 1'b0;
            spur_grant = 1'b0;
            n_spur++;
        end else begin
            core_done <= d;
            core_dout <= d ? core_val : DW'($urandom);
        end
        left_in_empty  <= (lq.size() == 0);
        left_in_dout   <= (lq.size() != 0) ? lq[0] : '0;
        right_in_empty <= (rq.size() == 0);
        right_in_dout  <= (rq.size() != 0) ? rq[0] : '0;
        cyc++;
    end

    task automatic push_l(input logic [DW-1:0] v);
        lq.push_back(v);
        exp_l.push_back(v + DW'(1));
    endtask

    task automatic push_r(input logic [DW-1:0] v);
        rq.push_back(v);
        exp_r.push_back(v + DW'(1));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n = 0;
        while ((lq.size() != 0 || rq.size() != 0 || m_pend) && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk(tag, {63'd0, (lq.size() == 0 && rq.size() == 0 && !m_pend)}, 64'd1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int wl0, wr0, sp0, n;
        reset          = 1'b1;
        left_out_full  = 1'b0;
        right_out_full = 1'b0;
        left_in_empty  = 1'b1;
        right_in_empty = 1'b1;
        left_in_dout   = '0;
        right_in_dout  = '0;
        core_done      = 1'b0;
        core_dout      = '0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_strobes", {left_in_rd_en, right_in_rd_en, core_start, left_out_wr_en, right_out_wr_en, busy}, 64'd0);
        chk("rst_core", {core_ch, core_din}, 64'd0);
        chk("rst_out_din", {left_out_din, right_out_din}, 64'd0);
        chk("rst_cnt", {left_cnt, right_cnt}, 64'd0);
        reset = 1'b0;

        // Left only, L=2: outputs 2..5, five cycles per sample
        lat = 2;
        wr_cyc_l.delete();
        wr0 = n_wr_r;
        for (int i = 1; i <= 4; i++) push_l(DW'(i));
        wait_drain("t1_drain", 100);
        chk("t1_left_cnt", left_cnt, 64'd4);
        chk("t1_right_writes", n_wr_r - wr0, 64'd0);
        chk("t1_last_left", left_out_din, 64'h5);
        chk("t1_nwrites", wr_cyc_l.size(), 64'd4);
        for (int i = 1; i < 4 && i < wr_cyc_l.size(); i++)
            chk("t1_gap", wr_cyc_l[i] - wr_cyc_l[i-1], 64'd5);

        // Both loaded: strict alternation starting with left
        do_reset();
        grants_ch.delete();
        push_l(32'h10); push_l(32'h11);
        push_r(32'h20); push_r(32'h21);
        wait_drain("t2_drain", 100);
        chk("t2_ngrants", grants_ch.size(), 64'd4);
        for (int i = 0; i < 4 && i < grants_ch.size(); i++)
            chk("t2_core_ch_seq", grants_ch[i], 64'(i % 2));
        chk("t2_left_out", left_out_din, 64'h12);
        chk("t2_right_out", right_out_din, 64'h22);

        // Right output full: only left served until released
        @(negedge clock);
        right_out_full = 1'b1;
        wr0 = n_wr_r;
        push_l(32'h30); push_l(32'h31); push_l(32'h32);
        push_r(32'h40); push_r(32'h41);
        n = 0;
        while ((lq.size() != 0 || m_pend) && n < 100) begin @(negedge clock); n++; end
        repeat (4) @(negedge clock);
        chk("t3_right_blocked", rq.size(), 64'd2);
        chk("t3_right_no_write", n_wr_r - wr0, 64'd0);
        right_out_full = 1'b0;
        wait_drain("t3_drain", 100);
        chk("t3_right_resumed", n_wr_r - wr0, 64'd2);
        chk("t3_right_out", right_out_din, 64'h42);

        // Spurious core_done in IDLE, then in ISSUE
        sp0 = n_spur; wl0 = n_wr_l;
        spur_idle = 1'b1;
        repeat (4) @(negedge clock);
        chk("t4_spur_idle_sent", n_spur - sp0, 64'd1);
        chk("t4_idle_quiet", {busy, left_out_wr_en, right_out_wr_en}, 64'd0);
        spur_grant = 1'b1;
        push_l(32'h70);
        wait_drain("t4_drain", 100);
        chk("t4_spur_issue_sent", n_spur - sp0, 64'd2);
        chk("t4_one_write", n_wr_l - wl0, 64'd1);
        chk("t4_left_out", left_out_din, 64'h71);

        // Reset during WAIT drops the in-flight sample
        lat = 3;
        push_l(32'h50);
        n = 0;
        while (!(m_pend && cyc >= m_g + 2) && n < 50) begin @(negedge clock); n++; end
        chk("t5_reached_wait", {63'd0, (m_pend && cyc >= m_g + 2)}, 64'd1);
        push_l(32'h51);
        push_r(32'h60);
        grants_ch.delete();
        wl0 = n_wr_l;
        reset = 1'b1;
        @(negedge clock);
        chk("t5_rst_strobes", {left_in_rd_en, right_in_rd_en, core_start, left_out_wr_en, right_out_wr_en, busy}, 64'd0);
        chk("t5_rst_cnt", {left_cnt, right_cnt}, 64'd0);
        reset = 1'b0;
        wait_drain("t5_drain", 100);
        chk("t5_first_grant_left", (grants_ch.size() != 0) ? grants_ch[0] : -1, 64'd0);
        chk("t5_left_writes", n_wr_l - wl0, 64'd1);
        chk("t5_left_out", left_out_din, 64'h52);

        // Counter wrap on the 2-bit instance
        do_reset();
        lat = 1;
        for (int i = 0; i < 5; i++) push_l(DW'(32'h80 + i));
        wait_drain("t6_drain", 100);
        chk("t6_wrap_cnt", d2_left_cnt, 64'd1);
        chk("t6_wide_cnt", left_cnt, 64'd5);

        // Randomized traffic, full toggling and spurious done pulses
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lat = $urandom_range(1, 4);
            for (int c = 0; c < 200; c++) begin
                @(negedge clock);
                if ($urandom_range(0, 2) == 0 && lq.size() < 4) push_l(DW'($urandom));
                if ($urandom_range(0, 2) == 0 && rq.size() < 4) push_r(DW'($urandom));
                if ($urandom_range(0, 15) == 0) left_out_full  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) right_out_full = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) spur_idle = 1'b1;
            end
            left_out_full  = 1'b0;
            right_out_full = 1'b0;
            wait_drain("rand_drain", 400);
            chk("rand_exp_empty", exp_l.size() + exp_r.size(), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
